// File: rtl/hs_elastic_fifo.sv
// Elastic FIFO between two four-phase req/ack bundled-data handshakes.
// Inputs are synchronised, words are buffered in order and replayed downstream.
`timescale 1ns/1ps

module hs_elastic_fifo #(
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_in,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic                           ack_out,
  output logic                           req_out,
  input  logic                           ack_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int NS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IN_IDLE,
    IN_HOLD
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_REL
  } out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [NS-1:0]         req_sync, ack_sync;
  logic                  req_s, ack_s;
  logic                  wr_en, load, pop;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers: with SYNC_STAGES = 0 the raw inputs are still
  // registered once so every decision is taken on a flopped value.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync[0] <= req_in;
      ack_sync[0] <= ack_in;
      for (int i = 1; i < NS; i++) begin
        req_sync[i] <= req_sync[i-1];
        ack_sync[i] <= ack_sync[i-1];
      end
    end
  end

  assign req_s = req_sync[NS-1];
  assign ack_s = ack_sync[NS-1];

  // ---------------------------------------------------------------------------
  // Input (upstream) FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_state <= IN_IDLE;
    else        in_state <= in_next;
  end

  always_comb begin
    in_next = in_state;
    unique case (in_state)
      IN_IDLE: if (wr_en)  in_next = IN_HOLD;
      IN_HOLD: if (!req_s) in_next = IN_IDLE;
      default:             in_next = IN_IDLE;
    endcase
  end

  // NOTE: every signal driven from always_comb gets a value on every path
  // (here directly, elsewhere via a default first) so no latch is inferred.
  always_comb begin
    ack_out = (in_state == IN_HOLD);
    // Backpressure uses the registered full flag; a pop on the same edge
    // lets the pending write through one edge later.
    wr_en   = (in_state == IN_IDLE) && req_s && !full;
  end

  // ---------------------------------------------------------------------------
  // Output (downstream) FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_state <= OUT_IDLE;
    else        out_state <= out_next;
  end

  always_comb begin
    out_next = out_state;
    unique case (out_state)
      OUT_IDLE: if (load)   out_next = OUT_REQ;
      OUT_REQ:  if (pop)    out_next = OUT_REL;
      OUT_REL:  if (!ack_s) out_next = OUT_IDLE;
      default:              out_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    req_out = (out_state == OUT_REQ);
    load    = (out_state == OUT_IDLE) && !empty && !ack_s;
    pop     = (out_state == OUT_REQ) && ack_s;
  end

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; count and pointers define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);

      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // data_out only moves on the IDLE->REQ load, so it is stable for the
      // whole downstream handshake including the release phase.
      if (load) data_out <= mem[rd_ptr];
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Self-checking bench for hs_elastic_fifo: directed timing cases plus a random
// stream checked against a queue-based reference of the FIFO contract.
`timescale 1ns/1ps

module tb_hs_elastic_fifo;

  localparam int DW    = 3;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_in;
  logic [DW-1:0] data_in;
  logic          ack_out;
  logic          req_out;
  logic          ack_in;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic man_ack  = 1'b0;
  logic auto_ack = 1'b0;
  int   cons_mode = 0;   // 0: never ack, 1: ack after 2 cycles, 2: random 0..5
  int   cons_d, cons_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  int            writes, pops;
  logic          prev_ack, prev_req;
  logic [DW-1:0] prev_data;

  assign ack_in = man_ack | auto_ack;

  always #5 clk = ~clk;

  hs_elastic_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .data_in (data_in),
    .ack_out (ack_out),
    .req_out (req_out),
    .ack_in  (ack_in),
    .data_out(data_out),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Occupancy is writes minus pops, where a write is an ack_out rise and a pop
  // is a req_out fall; words must emerge in the order they were accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      writes    = 0;
      pops      = 0;
      prev_ack  = ack_out;
      prev_req  = req_out;
      prev_data = data_out;
      exp_q.delete();
    end else begin
      if (ack_out && !prev_ack) begin
        writes++;
        exp_q.push_back(data_in);
      end
      if (!req_out && prev_req) pops++;
      if (req_out && !prev_req) begin
        check("q_nonempty_on_req", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("data_order", data_out, exp_q.pop_front());
      end else begin
        check("data_out_stable", data_out, prev_data);
      end
      check("count_model", count, writes - pops);
      check("count_le_depth", 32'(count <= DEPTH), 1);
      check("full_model", full, 32'((writes - pops) == DEPTH));
      check("empty_model", empty, 32'((writes - pops) == 0));
      prev_ack  = ack_out;
      prev_req  = req_out;
      prev_data = data_out;
    end
  end

  // Downstream consumer
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cons_mode != 0 && req_out && !auto_ack) begin
        cons_d = (cons_mode == 1) ? 2 : int'($urandom_range(0, 5));
        repeat (cons_d) @(negedge clk);
        auto_ack = 1'b1;
        cons_n = 0;
        while (req_out && cons_n < 500) begin
          @(negedge clk);
          cons_n++;
        end
        auto_ack = 1'b0;
      end
    end
  end

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (ack_out !== lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, ack_out, lvl);
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    while (req_out !== lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, req_out, lvl);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!(empty === 1'b1 && req_out === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, empty, 1);
  endtask

  task automatic push(input logic [DW-1:0] d);
    data_in = d;
    req_in  = 1'b1;
    @(negedge clk);
    wait_ack(1'b1, "push_ack");
    req_in = 1'b0;
    wait_ack(1'b0, "push_release");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack_out"},  ack_out,  0);
    check({tag, "_req_out"},  req_out,  0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_count"},    count,    0);
    check({tag, "_full"},     full,     0);
    check({tag, "_empty"},    empty,    1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req_in  = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word, latency of ack rise/fall and of req_out
    data_in = 3'd1;
    req_in  = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_ack_not_yet", ack_out, 0);
    @(negedge clk);
    check("t1_ack_rise", ack_out, 1);
    check("t1_count", count, 1);
    check("t1_req_not_yet", req_out, 0);
    req_in = 1'b0;
    @(negedge clk);
    check("t1_req_rise", req_out, 1);
    check("t1_data_out", data_out, 1);
    @(negedge clk);
    check("t1_ack_held", ack_out, 1);
    @(negedge clk);
    check("t1_ack_fall", ack_out, 0);
    cons_mode = 1;
    wait_empty("t1_drain");

    // 2: ordering 1..4 with a fixed-delay consumer
    for (int i = 1; i <= 4; i++) push(DW'(i));
    wait_empty("t2_drain");
    check("t2_count_zero", count, 0);

    // 3: full backpressure and release by one pop
    cons_mode = 0;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 4; i++) push(DW'(i));
    check("t3_full", full, 1);
    check("t3_count4", count, 4);
    data_in = 3'd5;
    req_in  = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_backpressure", ack_out, 0);
    check("t3_still_full", full, 1);
    check("t3_req_waiting", req_out, 1);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_req_before_pop", req_out, 1);
    @(negedge clk);
    check("t3_popped", req_out, 0);
    check("t3_count3", count, 3);
    check("t3_not_full", full, 0);
    check("t3_no_write_yet", ack_out, 0);
    @(negedge clk);
    check("t3_word5_ack", ack_out, 1);
    check("t3_count4_again", count, 4);
    check("t3_full_again", full, 1);
    man_ack = 1'b0;
    req_in  = 1'b0;
    wait_ack(1'b0, "t3_ack_fall");
    cons_mode = 2;
    wait_empty("t3_drain");

    // 5: simultaneous write and pop at count 2
    cons_mode = 0;
    repeat (8) @(negedge clk);
    push(3'd6);
    push(3'd2);
    check("t5_count_before", count, 2);
    data_in = 3'd5;
    req_in  = 1'b1;
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_count_pre_edge", count, 2);
    check("t5_req_pre_edge", req_out, 1);
    @(negedge clk);
    check("t5_write", ack_out, 1);
    check("t5_pop", req_out, 0);
    check("t5_count_same", count, 2);
    check("t5_full", full, 0);
    check("t5_empty", empty, 0);
    req_in  = 1'b0;
    man_ack = 1'b0;
    wait_ack(1'b0, "t5_ack_fall");
    cons_mode = 2;
    wait_empty("t5_drain");

    // 4: random stream with random consumer delays (pointers wrap repeatedly)
    for (int i = 0; i < 40; i++) begin
      push(DW'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_empty("t4_drain");
    check("t4_scoreboard_empty", exp_q.size(), 0);

    // 6: reset in the middle of both handshakes
    cons_mode = 0;
    repeat (8) @(negedge clk);
    push(3'd1);
    push(3'd2);
    data_in = 3'd3;
    req_in  = 1'b1;
    @(negedge clk);
    wait_ack(1'b1, "t6_ack_held");
    check("t6_count3", count, 3);
    check("t6_req_high", req_out, 1);
    #2;
    rst_n  = 1'b0;
    req_in = 1'b0;
    #1;
    check_reset_values("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cons_mode = 1;
    @(negedge clk);
    data_in = 3'd7;
    req_in  = 1'b1;
    wait_req(1'b1, "t6_req_after_reset");
    check("t6_data7", data_out, 7);
    req_in = 1'b0;
    wait_ack(1'b0, "t6_ack_fall");
    wait_empty("t6_drain");
    check("final_scoreboard_empty", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
